// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Multiplies use a
//               shift-add loop, divides a restoring loop, one bit per cycle.
//               Sign handling is done on magnitudes and then corrected in the
//               FIX state. Divide-by-zero and signed overflow skip the loop.
//               Optional macro FAST_MUL_EN: multiplies use one combinational
//               product registered in a single CALC cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int                  c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    c_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t               r_state;
  logic [2:0]           r_funct3;
  logic [WIDTH-1:0]     r_oper;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;      // product, or {remainder, quotient}
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_negQ;     // product / quotient must be negated
  logic                 r_negR;     // remainder must be negated
  logic                 r_fast;     // result preloaded in r_acc low half
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;

  logic                 w_isDiv, w_isRem, w_sgnA, w_sgnB, w_negA, w_negB;
  logic                 w_divZero, w_divOvf, w_calcLast;
  logic [WIDTH-1:0]     w_magA, w_magB, w_fastRes, w_quo, w_rem, w_sel;
  logic [WIDTH:0]       w_shift, w_diff;
  logic [2*WIDTH-1:0]   w_divNext, w_mulNext, w_accNext, w_prod;

  // Operand decode at Start: signedness, magnitudes and fast-path detection
  always_comb begin
    w_isDiv   = Funct3[2];
    w_isRem   = Funct3[1];
    w_sgnA    = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3[2] & ~Funct3[0]);
    w_sgnB    = (Funct3 == 3'b001) | (Funct3[2] & ~Funct3[0]);
    w_negA    = w_sgnA & DataA[WIDTH-1];
    w_negB    = w_sgnB & DataB[WIDTH-1];
    w_magA    = w_negA ? -DataA : DataA;
    w_magB    = w_negB ? -DataB : DataB;
    w_divZero = w_isDiv & (DataB == '0);
    w_divOvf  = w_isDiv & ~Funct3[0] & (DataA == c_MIN) & (DataB == '1);
    if (w_divZero)
      w_fastRes = w_isRem ? DataA : '1;
    else
      w_fastRes = w_isRem ? '0 : DataA;
  end

  // One iteration of the restoring divide and of the multiply
  always_comb begin
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_oper};
    if (!w_diff[WIDTH])
      w_divNext = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_divNext = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
`ifdef FAST_MUL_EN
    w_mulNext  = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_oper};
    w_calcLast = r_funct3[2] ? (r_cnt == c_LAST) : 1'b1;
`else
    w_mulNext  = {({1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_oper} : '0)),
                  r_acc[WIDTH-1:1]};
    w_calcLast = (r_cnt == c_LAST);
`endif
    w_accNext = r_funct3[2] ? w_divNext : w_mulNext;
  end

  // Sign correction and output selection used in FIX
  always_comb begin
    w_prod = r_negQ ? -r_acc : r_acc;
    w_quo  = r_negQ ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_negR ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_sel  = w_prod[WIDTH-1:0];
    if (r_fast)
      w_sel = r_acc[WIDTH-1:0];
    else begin
      case (r_funct3)
        3'b000:                 w_sel = w_prod[WIDTH-1:0];
        3'b001, 3'b010, 3'b011: w_sel = w_prod[2*WIDTH-1:WIDTH];
        3'b100, 3'b101:         w_sel = w_quo;
        default:                w_sel = w_rem;
      endcase
    end
  end

  // Control FSM; Flush overrides every other input
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_oper   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_fast   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_funct3 <= Funct3;
              r_negQ   <= w_negA ^ w_negB;
              r_negR   <= w_negA;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_fast   <= w_divZero | w_divOvf;
              if (w_divZero | w_divOvf) begin
                r_acc   <= {{WIDTH{1'b0}}, w_fastRes};
                r_state <= S_FIX;
              end else begin
                r_oper  <= w_isDiv ? w_magB : w_magA;
                r_acc   <= {{WIDTH{1'b0}}, (w_isDiv ? w_magA : w_magB)};
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + 1'b1;
            if (w_calcLast)
              r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= w_sel;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule
`default_nettype wire
